// File: rtl/div_scheduler.sv
`default_nettype none
//============================================================================
// Module   : div_scheduler
// Shared RV32M DIV/DIVU/REM/REMU engine with round-robin requester arbiter.
// Revision : 1.0 - initial release
//============================================================================
module div_scheduler #(
  parameter int XLEN = 32,
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [XLEN*NREQ-1:0] req_rs1,
  input  logic [XLEN*NREQ-1:0] req_rs2,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [XLEN-1:0]      rsp_data,
  input  logic                 flush,
  output logic                 busy
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_RUN   = 3'd2,
    S_FIXUP = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t          r_state, w_next;
  logic [IDW-1:0]  r_rr, r_id, r_rsp_id, w_grant;
  logic            w_any, w_accept;
  logic [1:0]      r_op, w_op;
  logic [XLEN-1:0] r_rs1, r_rs2, w_rs1, w_rs2;
  logic [XLEN-1:0] r_rem, r_quo, r_div, r_rsp_data;
  logic [CW-1:0]   r_cnt;
  logic            r_neg_q, r_neg_r;
  logic            w_signed, w_div0, w_ovf;
  logic [XLEN-1:0] w_abs1, w_abs2, w_special, w_result, w_rem_sub;
  logic [XLEN:0]   w_rem_sh;
  logic            w_ge;

  // Round-robin search starting at the pointer, wrapping modulo NREQ
  always_comb begin
    w_grant = '0;
    w_any   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_any && req_valid[(int'(r_rr) + i) % NREQ]) begin
        w_grant = IDW'((int'(r_rr) + i) % NREQ);
        w_any   = 1'b1;
      end
    end
  end

  assign w_accept  = w_any && (r_state == S_IDLE) && !flush && reset;
  assign req_ready = w_accept ? (NREQ'(1) << w_grant) : '0;
  assign w_op      = req_op[int'(w_grant)*2 +: 2];
  assign w_rs1     = req_rs1[int'(w_grant)*XLEN +: XLEN];
  assign w_rs2     = req_rs2[int'(w_grant)*XLEN +: XLEN];

  assign w_signed  = ~r_op[0];
  assign w_abs1    = (w_signed && r_rs1[XLEN-1]) ? (XLEN'(0) - r_rs1) : r_rs1;
  assign w_abs2    = (w_signed && r_rs2[XLEN-1]) ? (XLEN'(0) - r_rs2) : r_rs2;
  assign w_div0    = (r_rs2 == '0);
  assign w_ovf     = w_signed && (r_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (r_rs2 == '1);

  always_comb begin
    w_special = '0;
    if (w_div0) w_special = r_op[1] ? r_rs1 : '1;
    else        w_special = r_op[1] ? '0 : r_rs1;
  end

  // The shifted partial remainder can exceed XLEN bits, hence the extra MSB
  assign w_rem_sh  = {r_rem, r_quo[XLEN-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_div});
  assign w_rem_sub = w_rem_sh[XLEN-1:0] - r_div;

  always_comb begin
    w_result = '0;
    case (r_op)
      2'b00:   w_result = r_neg_q ? (XLEN'(0) - r_quo) : r_quo;
      2'b01:   w_result = r_quo;
      2'b10:   w_result = r_neg_r ? (XLEN'(0) - r_rem) : r_rem;
      default: w_result = r_rem;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_SETUP;
      S_SETUP: if (flush) w_next = S_IDLE;
               else if (w_div0 || w_ovf) w_next = S_RESP;
               else w_next = S_RUN;
      S_RUN:   if (flush) w_next = S_IDLE;
               else if (r_cnt == CW'(1)) w_next = S_FIXUP;
      S_FIXUP: w_next = flush ? S_IDLE : S_RESP;
      S_RESP:  if (flush || rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr       <= '0;
      r_id       <= '0;
      r_op       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_div      <= '0;
      r_cnt      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_rsp_id   <= '0;
      r_rsp_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op  <= w_op;
          r_rs1 <= w_rs1;
          r_rs2 <= w_rs2;
          r_id  <= w_grant;
          r_rr  <= IDW'((int'(w_grant) + 1) % NREQ);
        end
        S_SETUP: begin
          r_neg_q  <= r_rs1[XLEN-1] ^ r_rs2[XLEN-1];
          r_neg_r  <= r_rs1[XLEN-1];
          r_div    <= w_abs2;
          r_rem    <= '0;
          r_quo    <= w_abs1;
          r_cnt    <= CW'(XLEN);
          r_rsp_id <= r_id;
          if (w_div0 || w_ovf) r_rsp_data <= w_special;
        end
        S_RUN: begin
          r_rem <= w_ge ? w_rem_sub : w_rem_sh[XLEN-1:0];
          r_quo <= {r_quo[XLEN-2:0], w_ge};
          r_cnt <= r_cnt - 1'b1;
        end
        S_FIXUP: r_rsp_data <= w_result;
        default: ;
      endcase
    end
  end

  assign rsp_valid = (r_state == S_RESP);
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/div_scheduler.md
Name: div_scheduler

Overview:
- Shared iterative divide/remainder engine for RV32M DIV/DIVU/REM/REMU, plus a round-robin arbiter for NREQ requesters (e.g. executor lanes).
- Requesters hand over an opcode and operands through a valid/ready handshake.
- The block sequences the signed pre-processing, the XLEN-step shift-subtract loop, sign fixup and the RISC-V special cases.
- It returns one tagged result on a shared response channel.

Parameters:
- XLEN, 32, operand/result width.
- NREQ, 2, number of requesters (>=1).
- IDW, 1, width of the requester-id field, $clog2(NREQ) minimum 1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high
- req_op  in  2*NREQ  per-requester op: 00 div, 01 divu, 10 rem, 11 remu
- req_rs1  in  XLEN*NREQ  per-requester dividend
- req_rs2  in  XLEN*NREQ  per-requester divisor
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  IDW  index of the requester that owns the result
- rsp_data  out  XLEN  quotient or remainder
- flush  in  1  abandon in-flight operation
- busy  out  1  high whenever state != IDLE

Behaviour:
- States: IDLE, SETUP, RUN, FIXUP, RESP.
- Reset (reset==0, async):
  - state=IDLE, rr pointer=0, counter=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, req_ready=0.
  - Any in-flight operation is dropped with no response.
- Arbitration (combinational, IDLE only):
  - Grant the first requester with req_valid set, searching from the rr pointer upward modulo NREQ.
  - req_ready[grant]=1 only in IDLE with flush==0.
  - On handshake: latch op, rs1, rs2 and id; rr pointer <= grant+1 mod NREQ; go to SETUP.
  - Requesters hold valid and data stable until ready. Operands are sampled only at the handshake.
- SETUP (1 cycle):
  - Signed ops use |rs1| and |rs2|. Record neg_q = rs1[XLEN-1]^rs2[XLEN-1] and neg_r = rs1[XLEN-1].
  - Divide by zero (rs2==0): div/divu give all-ones; rem/remu give rs1. Go to RESP.
  - Signed overflow (div/rem, rs1=1<<(XLEN-1), rs2=all-ones): div gives rs1, rem gives 0. Go to RESP.
  - Otherwise load remainder=0, quotient=|rs1|, counter=XLEN; go to RUN.
- RUN (exactly XLEN cycles), one restoring step per cycle:
  - Shift {remainder,quotient} left by 1.
  - If remainder >= divisor, subtract and set the quotient LSB.
  - Decrement the counter; at 1->0 go to FIXUP.
- FIXUP (1 cycle):
  - div: quotient, negated if neg_q. divu: quotient.
  - rem: remainder, negated if neg_r. remu: remainder.
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_id and rsp_data are registered and stable until the handshake.
  - On rsp_valid&&rsp_ready, go to IDLE. No new request is accepted in that same cycle; the earliest next accept is the following cycle.
- Latency, with the accept edge at cycle 0:
  - Normal op: rsp_valid first high in cycle XLEN+3 (35 for XLEN=32).
  - Special case: rsp_valid first high in cycle 2.
- flush:
  - In SETUP, RUN or FIXUP: go to IDLE next edge, no response.
  - In RESP: rsp_valid drops next edge, result discarded.
  - In IDLE: suppresses req_ready; no accept that cycle.
  - flush takes priority over a simultaneous rsp_ready.
- busy = (state != IDLE). All arithmetic is modulo 2^XLEN.

Test Plan:
- Requester 0 sends divu 100/7 -> accept at cycle 0; rsp_valid first high in cycle 35; rsp_data=14, rsp_id=0. Repeat with remu 100/7 -> rsp_data=2.
- Requester 1 sends signed div -7/2, then rem -7/2 -> rsp_data 0xFFFFFFFD (-3), then 0xFFFFFFFF (-1); rsp_id=1 both times.
- Special cases, response in cycle 2:
  - div 5/0 -> 0xFFFFFFFF.
  - remu 5/0 -> 5.
  - div 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - rem with the same operands -> 0.
- Both requesters hold valid continuously -> grants alternate 0,1,0,1. A requester that drops valid is skipped with no idle cycle. req_ready is never high for two requesters at once.
- rsp_ready held low for 10 cycles in RESP -> rsp_valid, rsp_id and rsp_data stay stable; no req_ready until one cycle after the handshake.
- Assert flush during RUN (cycle 10), then reset low during a later RUN -> no response; busy=0 at the next edge. Async reset clears all outputs without a clock edge, and the next request completes normally.
